// File: rtl/wr_req_buffer_if.sv
// Push-side and sink-side handshake bundle for wr_req_buffer.
// The slave modport is the buffer's view; master is the producer/sink environment.
interface wr_req_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic                  push_ready;

    logic                  valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  accept;

    modport slave (
        input  push_valid,
        input  push_data,
        input  push_addr,
        output push_ready,
        output valid,
        output data_out,
        output addr_out,
        input  accept
    );

    modport master (
        output push_valid,
        output push_data,
        output push_addr,
        input  push_ready,
        input  valid,
        input  data_out,
        input  addr_out,
        output accept
    );
endinterface

// File: rtl/wr_req_buffer.sv
// Write-request FIFO between a ready/valid producer and the write-request sink.
// Optional high-water-mark output hwm is enabled by defining WR_REQ_BUFFER_HWM_EN.
module wr_req_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     res_n,
    wr_req_buffer_if.slave           bus,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   level,
`ifdef WR_REQ_BUFFER_HWM_EN
    output logic [$clog2(DEPTH):0]   hwm,
`endif
    output logic                     overflow
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [PTR_W:0]     wr_ptr_next;
    logic [PTR_W:0]     rd_ptr_next;
    logic               empty;
    logic               full;
    logic               do_push;
    logic               do_pop;
    logic [ENTRY_W-1:0] head;

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                   (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

    assign bus.push_ready = !full;
    assign bus.valid      = !empty;

    assign do_push = bus.push_valid && !full;
    assign do_pop  = !empty && bus.accept;

    assign wr_ptr_next = do_push ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign rd_ptr_next = do_pop  ? (rd_ptr + PTR_ONE) : rd_ptr;

    assign level = wr_ptr - rd_ptr;

    assign head         = mem[rd_ptr[PTR_W-1:0]];
    assign bus.data_out = head[ENTRY_W-1:ADDR_WIDTH];
    assign bus.addr_out = head[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
        end
    end

    // Storage is reset so data_out/addr_out read zero out of reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {bus.push_data, bus.push_addr};
        end
    end

    // A set in the same cycle as clear takes priority.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            overflow <= 1'b0;
        end else if (bus.push_valid && full) begin
            overflow <= 1'b1;
        end else if (clear) begin
            overflow <= 1'b0;
        end
    end

`ifdef WR_REQ_BUFFER_HWM_EN
    logic [PTR_W:0] level_next;

    assign level_next = wr_ptr_next - rd_ptr_next;

    // Clear restarts tracking from the current level, or the new one if it rises.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            hwm <= '0;
        end else if (clear) begin
            hwm <= (level_next > level) ? level_next : level;
        end else if (level_next > hwm) begin
            hwm <= level_next;
        end
    end
`endif
endmodule

// File: tb/tb_wr_req_buffer.sv
// Scoreboard testbench for wr_req_buffer: directed pushes queue expected requests,
// a negedge monitor compares every handshake taken by the sink side.
module tb_wr_req_buffer;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } req_t;

    logic          clk;
    logic          res_n;
    logic          clear;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef WR_REQ_BUFFER_HWM_EN
    logic [LW-1:0] hwm;
`endif

    int   checks;
    int   failures;
    req_t sb[$];

    wr_req_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    wr_req_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .res_n    (res_n),
        .bus      (bus_if.slave),
        .clear    (clear),
        .level    (level),
`ifdef WR_REQ_BUFFER_HWM_EN
        .hwm      (hwm),
`endif
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [DW-1:0] pd, input logic [AW-1:0] pa,
                                 input logic acc, input logic clr);
        bus_if.push_valid = pv;
        bus_if.push_data  = pd;
        bus_if.push_addr  = pa;
        bus_if.accept     = acc;
        clear             = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectReq(input logic [DW-1:0] d, input logic [AW-1:0] a);
        req_t r;
        r.data = d;
        r.addr = a;
        sb.push_back(r);
    endtask

    // Monitor: any cycle the sink takes the head, it must match the oldest expected request.
    always @(negedge clk) begin
        if (res_n && bus_if.valid && bus_if.accept) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected actual=%0h/%0h expected=none t=%0t",
                         bus_if.data_out, bus_if.addr_out, $time);
            end else begin
                req_t r;
                r = sb.pop_front();
                checkOutput("sb_data", 32'(bus_if.data_out), 32'(r.data));
                checkOutput("sb_addr", 32'(bus_if.addr_out), 32'(r.addr));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        res_n    = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #12;
        checkOutput("rst_valid",      32'(bus_if.valid), 0);
        checkOutput("rst_push_ready", 32'(bus_if.push_ready), 1);
        checkOutput("rst_level",      32'(level), 0);
        checkOutput("rst_overflow",   32'(overflow), 0);
        checkOutput("rst_data",       32'(bus_if.data_out), 0);
        checkOutput("rst_addr",       32'(bus_if.addr_out), 0);
        @(negedge clk);
        res_n = 1'b1;
        tick();
        checkOutput("idle_valid", 32'(bus_if.valid), 0);

        // Single request into empty buffer, visible the next cycle
        $display("[TB] single push");
        applyStimulus(1'b1, 8'hA5, 4'h3, 1'b1, 1'b0);
        expectReq(8'hA5, 4'h3);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("single_valid", 32'(bus_if.valid), 1);
        checkOutput("single_data",  32'(bus_if.data_out), 32'hA5);
        checkOutput("single_addr",  32'(bus_if.addr_out), 32'h3);
        checkOutput("single_level", 32'(level), 1);
        tick();
        checkOutput("single_valid_after", 32'(bus_if.valid), 0);
        checkOutput("single_level_after", 32'(level), 0);

        // Fill to full with the sink stalled
        $display("[TB] fill and overflow");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i), 4'(i - 1), 1'b0, 1'b0);
            expectReq(8'(i), 4'(i - 1));
            tick();
        end
        checkOutput("full_level",      32'(level), 4);
        checkOutput("full_push_ready", 32'(bus_if.push_ready), 0);
        checkOutput("hold_data",       32'(bus_if.data_out), 32'h01);
        applyStimulus(1'b1, 8'h05, 4'h4, 1'b0, 1'b0);
        tick();
        checkOutput("ovf_set",    32'(overflow), 1);
        checkOutput("ovf_level",  32'(level), 4);
        checkOutput("hold_data2", 32'(bus_if.data_out), 32'h01);
        checkOutput("hold_valid", 32'(bus_if.valid), 1);

        // Push and accept while full: only the pop happens
        applyStimulus(1'b1, 8'h05, 4'h4, 1'b1, 1'b0);
        tick();
        checkOutput("fullpp_level", 32'(level), 3);
        checkOutput("fullpp_ready", 32'(bus_if.push_ready), 1);
        applyStimulus(1'b1, 8'h06, 4'h5, 1'b1, 1'b0);
        expectReq(8'h06, 4'h5);
        tick();
        checkOutput("pp_level", 32'(level), 3);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("drain_level", 32'(level), 0);
        checkOutput("drain_valid", 32'(bus_if.valid), 0);

        // Streaming through the pointer wrap
        $display("[TB] streaming");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 4'(i), 1'b1, 1'b0);
            expectReq(8'(8'h10 + i), 4'(i));
            tick();
            checkOutput("stream_level_le1", 32'(level <= 1), 1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_level_end", 32'(level), 0);

        // Overflow set/clear priority and high-water mark
        $display("[TB] clear behaviour");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 4'(i + 8), 1'b0, 1'b0);
            expectReq(8'(8'h20 + i), 4'(i + 8));
            tick();
        end
`ifdef WR_REQ_BUFFER_HWM_EN
        checkOutput("hwm_full", 32'(hwm), 4);
`endif
        applyStimulus(1'b1, 8'h24, 4'hC, 1'b0, 1'b1);
        tick();
        checkOutput("ovf_set_wins", 32'(overflow), 1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("ovf_cleared", 32'(overflow), 0);
        checkOutput("clear_level", 32'(level), 4);
`ifdef WR_REQ_BUFFER_HWM_EN
        checkOutput("hwm_after_clear_full", 32'(hwm), 4);
`endif
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("clear_drain_level", 32'(level), 0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("ovf_stays_clear", 32'(overflow), 0);
`ifdef WR_REQ_BUFFER_HWM_EN
        checkOutput("hwm_after_clear_empty", 32'(hwm), 0);
`endif

        // Asynchronous reset mid-operation discards contents
        $display("[TB] async reset");
        applyStimulus(1'b1, 8'h77, 4'h7, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h78, 4'h8, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("pre_rst_level", 32'(level), 2);
        #2;
        res_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(bus_if.valid), 0);
        checkOutput("async_level", 32'(level), 0);
        checkOutput("async_ready", 32'(bus_if.push_ready), 1);
        checkOutput("async_data",  32'(bus_if.data_out), 0);
        @(negedge clk);
        res_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", 32'(bus_if.valid), 0);

        checkOutput("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
